// File: rtl/dsp_result_buffer_if.sv
// ============================================================================
// Module   : dsp_result_buffer_if
// Purpose  : Result-buffer bundle between the multiplier side, the issue logic
//            and the interconnect; the slave modport belongs to the buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dsp_result_buffer_if #(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 5
);
   localparam int c_CNT_W = $clog2(DEPTH + 1);

   logic                  issue_i;
   logic                  issue_ready_o;
   logic                  res_valid_i;
   logic [DATA_WIDTH-1:0] res_i;
   logic [TAG_WIDTH-1:0]  tag_i;
   logic [1:0]            status_i;
   logic                  valid_o;
   logic [DATA_WIDTH-1:0] res_o;
   logic [TAG_WIDTH-1:0]  tag_o;
   logic [1:0]            status_o;
   logic                  ack_i;
   logic [c_CNT_W-1:0]    count_o;
   logic                  overflow_o;

   modport slave (
      input  issue_i, res_valid_i, res_i, tag_i, status_i, ack_i,
      output issue_ready_o, valid_o, res_o, tag_o, status_o, count_o, overflow_o
   );

   modport master (
      output issue_i, res_valid_i, res_i, tag_i, status_i, ack_i,
      input  issue_ready_o, valid_o, res_o, tag_o, status_o, count_o, overflow_o
   );
endinterface

`default_nettype wire

// File: rtl/dsp_result_buffer.sv
// ============================================================================
// Module   : dsp_result_buffer
// Purpose  : Credit-controlled result FIFO behind the non-stallable multiplier.
//            Optional feature macro: DSP_RESBUF_BYPASS_EN (empty-FIFO bypass).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_result_buffer #(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 5
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   dsp_result_buffer_if.slave  bus
);
   localparam int c_CNT_W = $clog2(DEPTH + 1);
   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_ENT_W = DATA_WIDTH + TAG_WIDTH + 2;
   localparam logic [c_CNT_W-1:0] c_DEPTH     = c_CNT_W'(DEPTH);
   localparam logic [c_CNT_W:0]   c_DEPTH_EXT = (c_CNT_W + 1)'(DEPTH);
   localparam logic [c_PTR_W-1:0] c_LAST      = c_PTR_W'(DEPTH - 1);

   logic [c_ENT_W-1:0] r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic [c_CNT_W-1:0] r_inflight;
   logic               r_overflow;

   logic               w_empty;
   logic               w_full;
   logic               w_bypass;
   logic               w_pop;
   logic               w_push;
   logic               w_drop;
   logic               w_ready;
   logic               w_issue;
   logic               w_valid;
   logic [c_CNT_W:0]   w_credits_used;
   logic [c_ENT_W-1:0] w_in_entry;
   logic [c_ENT_W-1:0] w_head;

   always_comb begin
      w_empty    = (r_count == '0);
      w_full     = (r_count == c_DEPTH);
      w_in_entry = {bus.res_i, bus.tag_i, bus.status_i};
`ifdef DSP_RESBUF_BYPASS_EN
      w_bypass   = w_empty & bus.res_valid_i;
`else
      w_bypass   = 1'b0;
`endif
      w_pop      = ~w_empty & bus.ack_i;
      // A bypassed result consumed in the same cycle never touches storage.
      w_push     = bus.res_valid_i & (~w_full | w_pop) & ~(w_bypass & bus.ack_i);
      w_drop     = bus.res_valid_i & w_full & ~w_pop;
      // Built from registered state only, so issue_i never feeds back into ready.
      w_credits_used = {1'b0, r_count} + {1'b0, r_inflight};
      w_ready    = (w_credits_used < c_DEPTH_EXT);
      w_issue    = bus.issue_i & w_ready;
   end

   always_comb begin
      w_valid = 1'b0;
      w_head  = '0;
      if (!w_empty) begin
         w_valid = 1'b1;
         w_head  = r_mem[r_rd_ptr];
      end else if (w_bypass) begin
         w_valid = 1'b1;
         w_head  = w_in_entry;
      end
   end

   assign bus.valid_o                            = w_valid;
   assign {bus.res_o, bus.tag_o, bus.status_o}   = w_head;
   assign bus.issue_ready_o                      = w_ready;
   assign bus.count_o                            = r_count;
   assign bus.overflow_o                         = r_overflow;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_inflight <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;

         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;

         if (w_drop) r_overflow <= 1'b1;

         // Saturate at zero so an unsolicited result cannot wrap the credit count.
         if (w_issue && !bus.res_valid_i)
            r_inflight <= r_inflight + 1'b1;
         else if (!w_issue && bus.res_valid_i && (r_inflight != '0))
            r_inflight <= r_inflight - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= w_in_entry;
   end

   a_issue_needs_credit : assert property (
      @(posedge clk_i) disable iff (!rst_ni) !(bus.issue_i && !w_ready)
   );

endmodule

`default_nettype wire

// File: tb/tb_dsp_result_buffer.sv
// ============================================================================
// Module   : tb_dsp_result_buffer
// Purpose  : Directed self-checking bench for dsp_result_buffer (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsp_result_buffer;
   logic clk_i;
   logic rst_ni;
   int   vectors;
   int   miscompares;

   dsp_result_buffer_if #(.DEPTH(4), .DATA_WIDTH(32), .TAG_WIDTH(5)) bus ();

   dsp_result_buffer #(.DEPTH(4), .DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      bus.issue_i     = 1'b0;
      bus.res_valid_i = 1'b0;
      bus.res_i       = '0;
      bus.tag_i       = '0;
      bus.status_i    = '0;
      bus.ack_i       = 1'b0;
   endtask

   task automatic push_vals(input logic [31:0] r, input logic [4:0] t, input logic [1:0] s);
      bus.res_valid_i = 1'b1;
      bus.res_i       = r;
      bus.tag_i       = t;
      bus.status_i    = s;
   endtask

   task automatic test_reset();
      idle();
      rst_ni = 1'b0;
      tick();
      tick();
      vectors++;
      if (bus.valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
      vectors++;
      if (bus.count_o !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", bus.count_o); end
      vectors++;
      if (bus.overflow_o !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b want 0", bus.overflow_o); end
      vectors++;
      if (bus.issue_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", bus.issue_ready_o); end
      vectors++;
      if (bus.res_o !== 32'd0) begin miscompares++; $display("FAIL reset_res: got %h want 0", bus.res_o); end
      #3 rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_single();
      bus.issue_i = 1'b1;
      tick();
      bus.issue_i = 1'b0;
      vectors++;
      if (bus.issue_ready_o !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %b want 1", bus.issue_ready_o); end
      push_vals(32'hDEADBEEF, 5'd3, 2'b01);
      #1;
      vectors++;
`ifdef DSP_RESBUF_BYPASS_EN
      if (bus.valid_o !== 1'b1) begin miscompares++; $display("FAIL single_bypass_valid: got %b want 1", bus.valid_o); end
`else
      if (bus.valid_o !== 1'b0) begin miscompares++; $display("FAIL single_latency: got %b want 0", bus.valid_o); end
`endif
      tick();
      idle();
      vectors++;
      if (bus.valid_o !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", bus.valid_o); end
      vectors++;
      if (bus.res_o !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_res: got %h want deadbeef", bus.res_o); end
      vectors++;
      if (bus.tag_o !== 5'd3) begin miscompares++; $display("FAIL single_tag: got %0d want 3", bus.tag_o); end
      vectors++;
      if (bus.status_o !== 2'b01) begin miscompares++; $display("FAIL single_status: got %b want 01", bus.status_o); end
      vectors++;
      if (bus.count_o !== 3'd1) begin miscompares++; $display("FAIL single_count: got %0d want 1", bus.count_o); end
      bus.ack_i = 1'b1;
      tick();
      bus.ack_i = 1'b0;
      vectors++;
      if (bus.valid_o !== 1'b0) begin miscompares++; $display("FAIL single_pop_valid: got %b want 0", bus.valid_o); end
      vectors++;
      if (bus.count_o !== 3'd0) begin miscompares++; $display("FAIL single_pop_count: got %0d want 0", bus.count_o); end
      vectors++;
      if ({bus.res_o, bus.tag_o, bus.status_o} !== 39'd0) begin miscompares++; $display("FAIL single_zero_out: got %h want 0", {bus.res_o, bus.tag_o, bus.status_o}); end
      // a stray ack on an empty buffer must be ignored
      bus.ack_i = 1'b1;
      tick();
      bus.ack_i = 1'b0;
      vectors++;
      if (bus.count_o !== 3'd0) begin miscompares++; $display("FAIL single_stray_ack: got %0d want 0", bus.count_o); end
   endtask

   task automatic test_credits();
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (bus.issue_ready_o !== 1'b1) begin miscompares++; $display("FAIL credit_ready_%0d: got %b want 1", i, bus.issue_ready_o); end
         bus.issue_i = 1'b1;
         tick();
      end
      bus.issue_i = 1'b0;
      vectors++;
      if (bus.issue_ready_o !== 1'b0) begin miscompares++; $display("FAIL credit_exhausted: got %b want 0", bus.issue_ready_o); end
      for (int i = 0; i < 4; i++) begin
         push_vals(32'h1000_0000 + 32'(i), 5'(i), 2'b00);
         tick();
      end
      idle();
      vectors++;
      if (bus.count_o !== 3'd4) begin miscompares++; $display("FAIL credit_count: got %0d want 4", bus.count_o); end
      vectors++;
      if (bus.issue_ready_o !== 1'b0) begin miscompares++; $display("FAIL credit_full_ready: got %b want 0", bus.issue_ready_o); end
      vectors++;
      if (bus.tag_o !== 5'd0) begin miscompares++; $display("FAIL credit_head: got %0d want 0", bus.tag_o); end
      bus.ack_i = 1'b1;
      tick();
      bus.ack_i = 1'b0;
      vectors++;
      if (bus.issue_ready_o !== 1'b1) begin miscompares++; $display("FAIL credit_freed: got %b want 1", bus.issue_ready_o); end
      vectors++;
      if (bus.count_o !== 3'd3) begin miscompares++; $display("FAIL credit_after_ack: got %0d want 3", bus.count_o); end
      bus.ack_i = 1'b1;
      tick();
      tick();
      tick();
      bus.ack_i = 1'b0;
      vectors++;
      if (bus.count_o !== 3'd0) begin miscompares++; $display("FAIL credit_drain: got %0d want 0", bus.count_o); end
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 4; i++) begin
         push_vals(32'hA000_0000 + 32'(i), 5'(i), 2'(i));
         tick();
      end
      idle();
      vectors++;
      if (bus.count_o !== 3'd4) begin miscompares++; $display("FAIL full_count: got %0d want 4", bus.count_o); end
      vectors++;
      if (bus.tag_o !== 5'd0) begin miscompares++; $display("FAIL full_head: got %0d want 0", bus.tag_o); end
      push_vals(32'hA000_0004, 5'd4, 2'd0);
      bus.ack_i = 1'b1;
      tick();
      idle();
      vectors++;
      if (bus.count_o !== 3'd4) begin miscompares++; $display("FAIL fullpp_count: got %0d want 4", bus.count_o); end
      vectors++;
      if (bus.overflow_o !== 1'b0) begin miscompares++; $display("FAIL fullpp_overflow: got %b want 0", bus.overflow_o); end
      for (int i = 1; i <= 4; i++) begin
         vectors++;
         if (bus.tag_o !== 5'(i) || bus.res_o !== 32'hA000_0000 + 32'(i)) begin
            miscompares++;
            $display("FAIL fullpp_order_%0d: got tag %0d res %h want tag %0d res %h", i, bus.tag_o, bus.res_o, i, 32'hA000_0000 + 32'(i));
         end
         bus.ack_i = 1'b1;
         tick();
         bus.ack_i = 1'b0;
      end
      vectors++;
      if (bus.count_o !== 3'd0) begin miscompares++; $display("FAIL fullpp_drain: got %0d want 0", bus.count_o); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 4; i++) begin
         push_vals(32'hB000_0000 + 32'(i), 5'(8 + i), 2'b10);
         tick();
      end
      push_vals(32'hFFFF_FFFF, 5'd15, 2'b11);
      tick();
      idle();
      vectors++;
      if (bus.overflow_o !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b want 1", bus.overflow_o); end
      vectors++;
      if (bus.count_o !== 3'd4) begin miscompares++; $display("FAIL ovf_count: got %0d want 4", bus.count_o); end
      tick();
      vectors++;
      if (bus.overflow_o !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow_o); end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (bus.tag_o !== 5'(8 + i) || bus.res_o !== 32'hB000_0000 + 32'(i)) begin
            miscompares++;
            $display("FAIL ovf_data_%0d: got tag %0d res %h want tag %0d res %h", i, bus.tag_o, bus.res_o, 8 + i, 32'hB000_0000 + 32'(i));
         end
         bus.ack_i = 1'b1;
         tick();
         bus.ack_i = 1'b0;
      end
      vectors++;
      if (bus.valid_o !== 1'b0 || bus.overflow_o !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_after_drain: got valid %b ovf %b want valid 0 ovf 1", bus.valid_o, bus.overflow_o);
      end
   endtask

   task automatic test_reset_mid();
      push_vals(32'hC0C0_C0C0, 5'd1, 2'b00);
      tick();
      push_vals(32'hC0C0_C0C1, 5'd2, 2'b00);
      tick();
      idle();
      bus.issue_i = 1'b1;
      tick();
      bus.issue_i = 1'b0;
      vectors++;
      if (bus.count_o !== 3'd2) begin miscompares++; $display("FAIL mid_pre_count: got %0d want 2", bus.count_o); end
      rst_ni = 1'b0;
      #1;
      vectors++;
      if (bus.valid_o !== 1'b0 || bus.count_o !== 3'd0) begin
         miscompares++;
         $display("FAIL mid_reset_fifo: got valid %b count %0d want 0 0", bus.valid_o, bus.count_o);
      end
      vectors++;
      if (bus.overflow_o !== 1'b0) begin miscompares++; $display("FAIL mid_reset_ovf: got %b want 0", bus.overflow_o); end
      vectors++;
      if (bus.issue_ready_o !== 1'b1) begin miscompares++; $display("FAIL mid_reset_ready: got %b want 1", bus.issue_ready_o); end
      #2 rst_ni = 1'b1;
      tick();
      // four credits must be free again: issue three, ready must still be high
      bus.issue_i = 1'b1;
      tick();
      tick();
      tick();
      bus.issue_i = 1'b0;
      vectors++;
      if (bus.issue_ready_o !== 1'b1) begin miscompares++; $display("FAIL mid_credits_reset: got %b want 1", bus.issue_ready_o); end
      push_vals(32'h0, 5'd0, 2'b00);
      tick();
      tick();
      tick();
      idle();
      bus.ack_i = 1'b1;
      tick();
      tick();
      tick();
      bus.ack_i = 1'b0;
   endtask

   task automatic test_wrap();
      push_vals(32'hD000_0000, 5'd0, 2'b00);
      tick();
      for (int i = 1; i < 10; i++) begin
         vectors++;
         if (bus.tag_o !== 5'(i - 1) || bus.res_o !== 32'hD000_0000 + 32'(i - 1) || bus.count_o !== 3'd1) begin
            miscompares++;
            $display("FAIL wrap_%0d: got tag %0d res %h count %0d want tag %0d count 1", i - 1, bus.tag_o, bus.res_o, bus.count_o, i - 1);
         end
         push_vals(32'hD000_0000 + 32'(i), 5'(i), 2'b00);
         bus.ack_i = 1'b1;
         tick();
      end
      idle();
      vectors++;
      if (bus.tag_o !== 5'd9) begin miscompares++; $display("FAIL wrap_last: got %0d want 9", bus.tag_o); end
      bus.ack_i = 1'b1;
      tick();
      bus.ack_i = 1'b0;
      vectors++;
      if (bus.count_o !== 3'd0) begin miscompares++; $display("FAIL wrap_drain: got %0d want 0", bus.count_o); end
   endtask

`ifdef DSP_RESBUF_BYPASS_EN
   task automatic test_bypass();
      push_vals(32'h1234_5678, 5'd7, 2'b10);
      bus.ack_i = 1'b1;
      #1;
      vectors++;
      if (bus.valid_o !== 1'b1 || bus.tag_o !== 5'd7 || bus.res_o !== 32'h1234_5678) begin
         miscompares++;
         $display("FAIL bypass_same_cycle: got valid %b tag %0d res %h want 1 7 12345678", bus.valid_o, bus.tag_o, bus.res_o);
      end
      tick();
      idle();
      vectors++;
      if (bus.count_o !== 3'd0 || bus.valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL bypass_no_write: got count %0d valid %b want 0 0", bus.count_o, bus.valid_o);
      end
      push_vals(32'h0BAD_F00D, 5'd9, 2'b01);
      tick();
      idle();
      vectors++;
      if (bus.count_o !== 3'd1 || bus.tag_o !== 5'd9) begin
         miscompares++;
         $display("FAIL bypass_no_ack_write: got count %0d tag %0d want 1 9", bus.count_o, bus.tag_o);
      end
      bus.ack_i = 1'b1;
      tick();
      bus.ack_i = 1'b0;
   endtask
`endif

   initial begin
      vectors     = 0;
      miscompares = 0;
      idle();
      rst_ni = 1'b0;
      test_reset();
      test_single();
      test_credits();
      test_full_push_pop();
      test_overflow();
      test_reset_mid();
      test_wrap();
`ifdef DSP_RESBUF_BYPASS_EN
      test_bypass();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
